// File: rtl/ro_puf_ctrl.sv
// ro_puf_ctrl: challenge/response sequencer for a ring-oscillator PUF array.
//
// Purpose: a challenge selects two ring oscillators (sel_a, sel_b). Only those two are
// enabled. They run for SETTLE cycles so the synchronizers can flush. Their rising
// edges are then counted for WINDOW cycles. The two counts are compared to produce
// one response bit.
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous reset, active-high
//   start_i      request an evaluation (sampled only while idle)
//   challenge_i  {sel_a, sel_b}, SEL_W bits each
//   ro_in_i      raw asynchronous oscillator outputs
//   ro_en_o      per-oscillator enable (the selected pair while running)
//   busy_o       high in every state except IDLE
//   done_o       one-cycle pulse: results below are valid
//   response_o   count_a > count_b
//   tie_o        count_a == count_b
//   overflow_o   a counter saturated during the window
//   err_o        sel_a == sel_b, no measurement performed
//   count_a_o    final edge count of oscillator sel_a
//   count_b_o    final edge count of oscillator sel_b
module ro_puf_ctrl #(
  parameter int NUM_RO = 16,
  parameter int SEL_W  = 4,
  parameter int CNT_W  = 16,
  parameter int WINDOW = 1024,
  parameter int SETTLE = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [2*SEL_W-1:0]   challenge_i,
  input  logic [NUM_RO-1:0]    ro_in_i,
  output logic [NUM_RO-1:0]    ro_en_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 response_o,
  output logic                 tie_o,
  output logic                 overflow_o,
  output logic                 err_o,
  output logic [CNT_W-1:0]     count_a_o,
  output logic [CNT_W-1:0]     count_b_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETTLE  = 3'd1;
  localparam logic [2:0] S_MEASURE = 3'd2;
  localparam logic [2:0] S_COMPARE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW - 1);

  // Saturating increment. The MSB of the result flags an edge that was lost
  // because the counter was already at its maximum.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] c, input logic hit);
    if (!hit)
      return {1'b0, c};
    if (&c)
      return {1'b1, c};
    return {1'b0, c + CNT_W'(1)};
  endfunction

  logic [2:0]        state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [SEL_W-1:0]  sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic [CNT_W-1:0]  cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic              ovf_q, ovf_d;
  logic              resp_q, resp_d, tie_q, tie_d, ovf_out_q, ovf_out_d, err_q, err_d;
  logic [CNT_W-1:0]  cnt_a_out_q, cnt_a_out_d, cnt_b_out_q, cnt_b_out_d;

  logic [NUM_RO-1:0] ro_sync_p0_q, ro_sync_p1_q, ro_prev_p2_q;
  logic [NUM_RO-1:0] rise;
  logic [CNT_W:0]    inc_a, inc_b;

  // Stage p0/p1: two-flop synchronizer; stage p2: previous value for edge detection
  assign rise  = ro_sync_p1_q & ~ro_prev_p2_q;
  assign inc_a = sat_inc(cnt_a_q, rise[sel_a_q]);
  assign inc_b = sat_inc(cnt_b_q, rise[sel_b_q]);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    sel_a_d     = sel_a_q;
    sel_b_d     = sel_b_q;
    cnt_a_d     = cnt_a_q;
    cnt_b_d     = cnt_b_q;
    ovf_d       = ovf_q;
    resp_d      = resp_q;
    tie_d       = tie_q;
    ovf_out_d   = ovf_out_q;
    err_d       = err_q;
    cnt_a_out_d = cnt_a_out_q;
    cnt_b_out_d = cnt_b_out_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          sel_a_d     = challenge_i[2*SEL_W-1:SEL_W];
          sel_b_d     = challenge_i[SEL_W-1:0];
          cnt_a_d     = '0;
          cnt_b_d     = '0;
          ovf_d       = 1'b0;
          timer_d     = '0;
          resp_d      = 1'b0;
          tie_d       = 1'b0;
          ovf_out_d   = 1'b0;
          cnt_a_out_d = '0;
          cnt_b_out_d = '0;
          if (challenge_i[2*SEL_W-1:SEL_W] == challenge_i[SEL_W-1:0]) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (timer_q == SETTLE_LAST) begin
          timer_d = '0;
          state_d = S_MEASURE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_MEASURE: begin
        cnt_a_d = inc_a[CNT_W-1:0];
        cnt_b_d = inc_b[CNT_W-1:0];
        // Overflow is sticky for the whole window once any edge is lost.
        ovf_d   = ovf_q | inc_a[CNT_W] | inc_b[CNT_W];
        if (timer_q == WINDOW_LAST) begin
          timer_d = '0;
          state_d = S_COMPARE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_COMPARE: begin
        resp_d      = cnt_a_q > cnt_b_q;
        tie_d       = cnt_a_q == cnt_b_q;
        ovf_out_d   = ovf_q;
        cnt_a_out_d = cnt_a_q;
        cnt_b_out_d = cnt_b_q;
        state_d     = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      sel_a_q      <= '0;
      sel_b_q      <= '0;
      cnt_a_q      <= '0;
      cnt_b_q      <= '0;
      ovf_q        <= 1'b0;
      resp_q       <= 1'b0;
      tie_q        <= 1'b0;
      ovf_out_q    <= 1'b0;
      err_q        <= 1'b0;
      cnt_a_out_q  <= '0;
      cnt_b_out_q  <= '0;
      ro_sync_p0_q <= '0;
      ro_sync_p1_q <= '0;
      ro_prev_p2_q <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      sel_a_q      <= sel_a_d;
      sel_b_q      <= sel_b_d;
      cnt_a_q      <= cnt_a_d;
      cnt_b_q      <= cnt_b_d;
      ovf_q        <= ovf_d;
      resp_q       <= resp_d;
      tie_q        <= tie_d;
      ovf_out_q    <= ovf_out_d;
      err_q        <= err_d;
      cnt_a_out_q  <= cnt_a_out_d;
      cnt_b_out_q  <= cnt_b_out_d;
      ro_sync_p0_q <= ro_in_i;
      ro_sync_p1_q <= ro_sync_p0_q;
      ro_prev_p2_q <= ro_sync_p1_q;
    end
  end

  // Enables are decoded from state so they can only be high in SETTLE/MEASURE,
  // and only the two latched lanes can be set.
  always_comb begin
    ro_en_o = '0;
    if (state_q == S_SETTLE || state_q == S_MEASURE) begin
      ro_en_o[sel_a_q] = 1'b1;
      ro_en_o[sel_b_q] = 1'b1;
    end
  end

  assign busy_o     = state_q != S_IDLE;
  assign done_o     = state_q == S_DONE;
  assign response_o = resp_q;
  assign tie_o      = tie_q;
  assign overflow_o = ovf_out_q;
  assign err_o      = err_q;
  assign count_a_o  = cnt_a_out_q;
  assign count_b_o  = cnt_b_out_q;

endmodule

// File: tb/tb_ro_puf_ctrl.sv
module tb_ro_puf_ctrl;

  localparam int NRO  = 16;
  localparam int S    = 8;
  localparam int W_A  = 1024;
  localparam int CW_A = 16;
  localparam int W_B  = 256;
  localparam int CW_B = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic which = 1'b0;
  logic [7:0] challenge = '0;
  logic [NRO-1:0] ro_in = '0;

  logic [NRO-1:0] en_a, en_b;
  logic busy_a, done_a, resp_a, tie_a, ovf_a, err_a;
  logic busy_b, done_b, resp_b, tie_b, ovf_b, err_b;
  logic [CW_A-1:0] ca_a, cb_a;
  logic [CW_B-1:0] ca_b, cb_b;

  logic start_a, start_b;
  assign start_a = start & ~which;
  assign start_b = start & which;

  ro_puf_ctrl #(.NUM_RO(NRO), .SEL_W(4), .CNT_W(CW_A), .WINDOW(W_A), .SETTLE(S)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .challenge_i(challenge), .ro_in_i(ro_in),
    .ro_en_o(en_a), .busy_o(busy_a), .done_o(done_a), .response_o(resp_a), .tie_o(tie_a),
    .overflow_o(ovf_a), .err_o(err_a), .count_a_o(ca_a), .count_b_o(cb_a));

  ro_puf_ctrl #(.NUM_RO(NRO), .SEL_W(4), .CNT_W(CW_B), .WINDOW(W_B), .SETTLE(S)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .challenge_i(challenge), .ro_in_i(ro_in),
    .ro_en_o(en_b), .busy_o(busy_b), .done_o(done_b), .response_o(resp_b), .tie_o(tie_b),
    .overflow_o(ovf_b), .err_o(err_b), .count_a_o(ca_b), .count_b_o(cb_b));

  // Outputs of whichever instance is under test.
  logic [NRO-1:0] o_en;
  logic o_busy, o_done, o_resp, o_tie, o_ovf, o_err;
  logic [15:0] o_ca, o_cb;
  assign o_en   = which ? en_b   : en_a;
  assign o_busy = which ? busy_b : busy_a;
  assign o_done = which ? done_b : done_a;
  assign o_resp = which ? resp_b : resp_a;
  assign o_tie  = which ? tie_b  : tie_a;
  assign o_ovf  = which ? ovf_b  : ovf_a;
  assign o_err  = which ? err_b  : err_a;
  assign o_ca   = which ? {12'b0, ca_b} : ca_a;
  assign o_cb   = which ? {12'b0, cb_b} : cb_a;

  always #5 clk = ~clk;

  // Edge index and history of the oscillator levels seen at each rising clock edge.
  int edge_n = 0;
  logic [NRO-1:0] hist [0:65535];
  always @(posedge clk) begin
    edge_n = edge_n + 1;
    hist[edge_n & 16'hFFFF] = ro_in;
  end

  // Oscillator waveform generator: square waves of per-lane period/high-time/phase.
  int per [NRO];
  int hi  [NRO];
  int ph  [NRO];
  always @(negedge clk) begin
    for (int l = 0; l < NRO; l++)
      ro_in[l] = ((edge_n + ph[l]) % per[l]) < hi[l];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int l, input int p, input int h, input int f);
    per[l] = p; hi[l] = h; ph[l] = f;
  endtask

  task automatic randomize_lanes();
    for (int l = 0; l < NRO; l++) begin
      per[l] = $urandom_range(3, 24);
      hi[l]  = $urandom_range(1, per[l] - 1);
      ph[l]  = $urandom_range(0, per[l] - 1);
    end
  endtask

  // One full evaluation on the selected instance, checked against a reference that
  // counts the rising edges in the sampled history over the measurement window.
  task automatic run_eval(input int sa, input int sb, input bit hold);
    int k, w, cw, lim, dn_edge, ndone, na, nb, mx;
    logic [NRO-1:0] pair, exp_en;
    logic [3:0] sa4, sb4;
    bit eerr, eov, eresp, etie;
    int ea, eb;
    w  = which ? W_B : W_A;
    cw = which ? CW_B : CW_A;
    sa4 = sa[3:0];
    sb4 = sb[3:0];
    @(negedge clk);
    start = 1'b1;
    challenge = {sa4, sb4};
    @(posedge clk);
    #1;
    k = edge_n;
    if (!hold) start = 1'b0;
    challenge = 8'($urandom);
    eerr = (sa == sb);
    pair = '0;
    if (!eerr) begin
      pair[sa] = 1'b1;
      pair[sb] = 1'b1;
    end
    lim = eerr ? k : k + S + w + 1;
    ndone = 0;
    dn_edge = -1;
    while (edge_n < lim + 3) begin
      @(negedge clk);
      exp_en = (!eerr && edge_n >= k && edge_n <= k + S + w - 1) ? pair : '0;
      chk("ro_en", 32'(o_en), 32'(exp_en));
      chk("busy", 32'(o_busy), 32'(edge_n <= lim));
      if (o_done) begin
        ndone++;
        dn_edge = edge_n;
        start = 1'b0;
      end
    end
    start = 1'b0;
    na = 0;
    nb = 0;
    if (!eerr) begin
      for (int t = k + S + 1; t <= k + S + w; t++) begin
        if (hist[(t - 2) & 16'hFFFF][sa] && !hist[(t - 3) & 16'hFFFF][sa]) na++;
        if (hist[(t - 2) & 16'hFFFF][sb] && !hist[(t - 3) & 16'hFFFF][sb]) nb++;
      end
    end
    mx    = (1 << cw) - 1;
    eov   = (na > mx) || (nb > mx);
    ea    = (na > mx) ? mx : na;
    eb    = (nb > mx) ? mx : nb;
    eresp = ea > eb;
    etie  = !eerr && (ea == eb);
    chk("done_count", ndone, 1);
    chk("done_edge", dn_edge, lim);
    chk("count_a", 32'(o_ca), ea);
    chk("count_b", 32'(o_cb), eb);
    chk("response", 32'(o_resp), 32'(eresp));
    chk("tie", 32'(o_tie), 32'(etie));
    chk("overflow", 32'(o_ovf), 32'(eov));
    chk("err", 32'(o_err), 32'(eerr));
  endtask

  initial begin
    int k, sa, sb;
    for (int l = 0; l < NRO; l++) set_lane(l, 6 + l, 3, l);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_en", 32'(o_en), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_flags", {28'b0, o_resp, o_tie, o_ovf, o_err}, 0);
    chk("rst_counts", {o_ca, o_cb}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Periods 8 and 10 on lanes 3 and 9
    set_lane(3, 8, 4, 0);
    set_lane(9, 10, 5, 3);
    run_eval(3, 9, 1'b0);
    chk("t2_resp_hi", 32'(o_resp), 1);

    // Identical waveforms on both lanes
    set_lane(4, 7, 3, 2);
    set_lane(11, 7, 3, 2);
    run_eval(4, 11, 1'b0);
    chk("t3_tie", 32'(o_tie), 1);

    // Equal selects take the error path
    run_eval(5, 5, 1'b0);

    // Start held high for the whole evaluation
    run_eval(12, 1, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("t6_idle_done", 32'(o_done), 0);
      chk("t6_idle_busy", 32'(o_busy), 0);
    end

    // Reset in the middle of the measurement window
    @(negedge clk);
    start = 1'b1;
    challenge = {4'd2, 4'd7};
    @(posedge clk);
    #1;
    k = edge_n;
    start = 1'b0;
    while (edge_n < k + S + 100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t1_en", 32'(o_en), 0);
    chk("t1_busy", 32'(o_busy), 0);
    chk("t1_done", 32'(o_done), 0);
    chk("t1_counts", {o_ca, o_cb}, 0);
    chk("t1_flags", {28'b0, o_resp, o_tie, o_ovf, o_err}, 0);
    @(negedge clk);
    rst = 1'b0;
    while (edge_n < k + S + W_A + 5) begin
      @(negedge clk);
      chk("t1_no_done", 32'(o_done), 0);
    end
    run_eval(2, 7, 1'b0);

    // Randomised evaluations on the wide-counter instance
    for (int i = 0; i < 5; i++) begin
      randomize_lanes();
      sa = $urandom_range(0, 15);
      sb = ($urandom_range(0, 4) == 0) ? sa : $urandom_range(0, 15);
      run_eval(sa, sb, 1'b0);
    end

    // Narrow-counter instance: saturation
    which = 1'b1;
    repeat (2) @(negedge clk);
    set_lane(0, 4, 2, 0);
    set_lane(1, 40, 20, 5);
    run_eval(0, 1, 1'b0);
    chk("t5_sat", 32'(o_ca), 15);
    chk("t5_ovf", 32'(o_ovf), 1);

    // Both lanes saturated: overflow and tie together
    set_lane(6, 5, 2, 1);
    set_lane(8, 6, 3, 4);
    run_eval(6, 8, 1'b0);

    for (int i = 0; i < 4; i++) begin
      randomize_lanes();
      per[i] = $urandom_range(16, 60);
      hi[i]  = per[i] / 2;
      sa = i;
      sb = $urandom_range(4, 15);
      run_eval(sa, sb, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
